// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receiver: FSM states, bit counter
// geometry and default parameter values.
package i2s_pkg;

    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = 6'd63;

    localparam int DEF_SAMPLE_WIDTH   = 16;
    localparam int DEF_I2S_DELAY      = 1;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchroniser followed by a history flop; provides the
// synchronised level and a one-clk strobe on its rising edge.
module i2s_sync (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic level,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic hist_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            hist_p2 <= 1'b0;
        end else begin
            sync_p0 <= sig;
            sync_p1 <= sync_p0;
            hist_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~hist_p2;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bck/ws/din in the clk domain, deserialises
// left/right slots and presents complete sample pairs with lock tracking.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH   = DEF_SAMPLE_WIDTH,
    parameter int I2S_DELAY      = DEF_I2S_DELAY,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i2s_bck,
    input  logic                    i2s_ws,
    input  logic                    i2s_din,
    output logic [SAMPLE_WIDTH-1:0] audio_l,
    output logic [SAMPLE_WIDTH-1:0] audio_r,
    output logic                    sample_valid,
    output logic                    locked,
    output logic                    frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(SAMPLE_WIDTH - 1);
    localparam logic [CNT_W-1:0] IDX_FULL = CNT_W'(SAMPLE_WIDTH);
    localparam bit DELAYED = (I2S_DELAY != 0);

    logic bck_level_unused;
    logic ws_rise_unused;
    logic din_rise_unused;
    logic bck_rise;
    logic ws_s;
    logic din_s;

    i2s_sync u_bck (.clk(clk), .reset(reset), .sig(i2s_bck), .level(bck_level_unused), .rise(bck_rise));
    i2s_sync u_ws  (.clk(clk), .reset(reset), .sig(i2s_ws),  .level(ws_s),  .rise(ws_rise_unused));
    i2s_sync u_din (.clk(clk), .reset(reset), .sig(i2s_din), .level(din_s), .rise(din_rise_unused));

    state_t                  state;
    logic                    ws_prev;
    logic [CNT_W-1:0]        bit_idx;
    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic [SAMPLE_WIDTH-1:0] hold_l;
    logic [TO_W-1:0]         to_cnt;

    logic                    ws_edge;
    logic                    take_old;
    logic                    old_shift;
    logic                    complete;
    logic                    short_slot;
    logic                    timeout_hit;
    logic [CNT_W-1:0]        idx_after;
    logic [SAMPLE_WIDTH-1:0] word;

    // In Philips mode the bit sampled with a ws edge is still the LSB of the
    // slot that is ending, so it is credited to the old slot before restarting.
    assign ws_edge     = bck_rise && (ws_s != ws_prev);
    assign take_old    = !ws_edge || DELAYED;
    assign old_shift   = take_old && (bit_idx < IDX_FULL);
    assign complete    = bck_rise && old_shift && (bit_idx == IDX_LAST);
    assign idx_after   = take_old ? sat_inc(bit_idx) : bit_idx;
    assign short_slot  = ws_edge && (state != SEEK) && (idx_after < IDX_FULL);
    assign timeout_hit = !bck_rise && (to_cnt >= TO_LAST);
    assign word        = {shift_reg[SAMPLE_WIDTH-2:0], din_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SEEK;
            ws_prev      <= 1'b0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            hold_l       <= '0;
            to_cnt       <= '0;
            audio_l      <= '0;
            audio_r      <= '0;
            sample_valid <= 1'b0;
            locked       <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;

            if (bck_rise)
                to_cnt <= '0;
            else if (to_cnt != TO_MAX)
                to_cnt <= to_cnt + 1'b1;

            if (timeout_hit) begin
                state  <= SEEK;
                locked <= 1'b0;
            end else if (bck_rise) begin
                ws_prev <= ws_s;

                if (ws_edge && !DELAYED) begin
                    shift_reg <= word;
                    bit_idx   <= 6'd1;
                end else begin
                    if (old_shift)
                        shift_reg <= word;
                    bit_idx <= ws_edge ? '0 : sat_inc(bit_idx);
                end

                case (state)
                    SEEK: begin
                        if (ws_edge && !ws_s)
                            state <= LEFT;
                    end
                    LEFT: begin
                        if (complete)
                            hold_l <= word;
                    end
                    RIGHT: begin
                        if (complete) begin
                            audio_l      <= hold_l;
                            audio_r      <= word;
                            sample_valid <= 1'b1;
                            locked       <= 1'b1;
                        end
                    end
                    default: state <= SEEK;
                endcase

                // A short slot drops the pair; ws=1 cannot start a frame, so resync.
                if (ws_edge && (state != SEEK)) begin
                    if (short_slot) begin
                        frame_err <= 1'b1;
                        locked    <= 1'b0;
                        state     <= ws_s ? SEEK : LEFT;
                    end else begin
                        state <= ws_s ? RIGHT : LEFT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: a Philips-mode instance and a left-justified
// instance, each fed by an oversampled serial stream driver.
module tb_i2s_rx;

    localparam int SW   = 16;
    localparam int TO   = 255;
    localparam int HALF = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic sel;
    logic bck, ws, din;
    logic prev_bit;
    int   cyc = 0;
    int   last_rise = 0;

    logic bck1, ws1, din1, bck0, ws0, din0;
    assign bck1 = sel & bck;
    assign ws1  = sel ? ws  : 1'b0;
    assign din1 = sel ? din : 1'b0;
    assign bck0 = ~sel & bck;
    assign ws0  = sel ? 1'b0 : ws;
    assign din0 = sel ? 1'b0 : din;

    logic [SW-1:0] audio_l1, audio_r1, audio_l0, audio_r0;
    logic          valid1, locked1, err1, valid0, locked0, err0;

    i2s_rx #(.SAMPLE_WIDTH(SW), .I2S_DELAY(1), .TIMEOUT_CYCLES(TO)) dut1 (
        .clk(clk), .reset(reset), .i2s_bck(bck1), .i2s_ws(ws1), .i2s_din(din1),
        .audio_l(audio_l1), .audio_r(audio_r1), .sample_valid(valid1),
        .locked(locked1), .frame_err(err1)
    );

    i2s_rx #(.SAMPLE_WIDTH(SW), .I2S_DELAY(0), .TIMEOUT_CYCLES(TO)) dut0 (
        .clk(clk), .reset(reset), .i2s_bck(bck0), .i2s_ws(ws0), .i2s_din(din0),
        .audio_l(audio_l0), .audio_r(audio_r0), .sample_valid(valid0),
        .locked(locked0), .frame_err(err0)
    );

    int tests = 0;
    int fails = 0;
    int vcnt1 = 0, vcnt0 = 0, ecnt1 = 0, ecnt0 = 0;
    logic [31:0] q1[$];
    logic [31:0] q0[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitors: pop the expected pair on every sample_valid pulse.
    always @(negedge clk) begin
        logic [31:0] e;
        if (valid1) begin
            vcnt1++;
            chk("q1_nonempty", {31'b0, q1.size() != 0}, 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("audio_l1", {16'b0, audio_l1}, {16'b0, e[31:16]});
                chk("audio_r1", {16'b0, audio_r1}, {16'b0, e[15:0]});
            end
        end
        if (valid0) begin
            vcnt0++;
            chk("q0_nonempty", {31'b0, q0.size() != 0}, 32'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("audio_l0", {16'b0, audio_l0}, {16'b0, e[31:16]});
                chk("audio_r0", {16'b0, audio_r0}, {16'b0, e[15:0]});
            end
        end
        if (err1) begin
            ecnt1++;
            chk("err_unlock1", {31'b0, locked1}, 32'd0);
        end
        if (err0) ecnt0++;
    end

    // One bck period; in Philips mode data lags ws by one bit.
    task automatic bitp(input logic w, input logic b);
        bck = 1'b0;
        ws  = w;
        din = sel ? prev_bit : b;
        prev_bit = b;
        repeat (HALF) @(negedge clk);
        bck = 1'b1;
        last_rise = cyc;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic slot(input logic w, input logic [15:0] word, input int nbits, input logic fill);
        for (int i = 0; i < nbits; i++)
            bitp(w, (i < 16) ? word[15-i] : fill);
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r, input int nbits, input logic fill);
        if (sel) q1.push_back({l, r});
        else     q0.push_back({l, r});
        slot(1'b0, l, nbits, fill);
        slot(1'b1, r, nbits, fill);
    endtask

    task automatic idle(input int n);
        bck = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0;
        reset = 1'b1; sel = 1'b1; bck = 1'b0; ws = 1'b0; din = 1'b0; prev_bit = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_l1",      {16'b0, audio_l1}, 32'd0);
        chk("rst_r1",      {16'b0, audio_r1}, 32'd0);
        chk("rst_valid1",  {31'b0, valid1},   32'd0);
        chk("rst_locked1", {31'b0, locked1},  32'd0);
        chk("rst_err1",    {31'b0, err1},     32'd0);
        chk("rst_l0",      {16'b0, audio_l0}, 32'd0);
        chk("rst_locked0", {31'b0, locked0},  32'd0);
        reset = 1'b0;
        idle(5);

        // T1 + T2: Philips 16-bit frame, then 32-bit slots with ones padding
        v0 = vcnt1; e0 = ecnt1;
        slot(1'b1, 16'h0000, 16, 1'b0);
        chk("t1_seek_locked", {31'b0, locked1}, 32'd0);
        frame(16'h1234, 16'hA5C3, 16, 1'b0);
        q1.push_back({16'h8001, 16'h7FFF});
        slot(1'b0, 16'h8001, 32, 1'b1);
        chk("t1_valid_cnt", vcnt1 - v0, 32'd1);
        chk("t1_l",      {16'b0, audio_l1}, 32'h1234);
        chk("t1_r",      {16'b0, audio_r1}, 32'hA5C3);
        chk("t1_locked", {31'b0, locked1},  32'd1);
        slot(1'b1, 16'h7FFF, 32, 1'b1);
        chk("t2_valid_cnt", vcnt1 - v0, 32'd2);
        chk("t2_l",   {16'b0, audio_l1}, 32'h8001);
        chk("t2_r",   {16'b0, audio_r1}, 32'h7FFF);
        chk("t2_err", ecnt1 - e0, 32'd0);

        // T3: short left slot, then recovery
        v0 = vcnt1;
        slot(1'b0, 16'h9999, 12, 1'b0);
        slot(1'b1, 16'h6666, 16, 1'b0);
        chk("t3_err_cnt", ecnt1 - e0, 32'd1);
        chk("t3_unlocked", {31'b0, locked1}, 32'd0);
        frame(16'h0F0F, 16'hF00F, 16, 1'b0);
        slot(1'b0, 16'h0000, 16, 1'b0);
        chk("t3_valid_cnt", vcnt1 - v0, 32'd1);
        chk("t3_relocked", {31'b0, locked1}, 32'd1);

        // T4: bck stalls; lock drops exactly TO cycles after the last detected rise
        bck = 1'b0;
        while (cyc < last_rise + 2 + TO) @(negedge clk);
        chk("t4_locked_before", {31'b0, locked1}, 32'd1);
        @(negedge clk);
        chk("t4_locked_after", {31'b0, locked1}, 32'd0);
        chk("t4_hold_l", {16'b0, audio_l1}, 32'h0F0F);
        chk("t4_hold_r", {16'b0, audio_r1}, 32'hF00F);
        slot(1'b1, 16'h0000, 16, 1'b0);
        chk("t4_pre_locked", {31'b0, locked1}, 32'd0);
        frame(16'hAAAA, 16'h5555, 16, 1'b0);
        slot(1'b0, 16'h0000, 16, 1'b0);
        chk("t4_relocked", {31'b0, locked1}, 32'd1);

        // T5: start mid-right slot, reset in mid-left slot
        idle(300);
        v0 = vcnt1;
        slot(1'b1, 16'h7777, 7, 1'b0);
        frame(16'h1111, 16'h2222, 16, 1'b0);
        slot(1'b0, 16'h3333, 8, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_rst_l",      {16'b0, audio_l1}, 32'd0);
        chk("t5_rst_r",      {16'b0, audio_r1}, 32'd0);
        chk("t5_rst_locked", {31'b0, locked1},  32'd0);
        reset = 1'b0;
        slot(1'b0, 16'h3333, 8, 1'b0);
        slot(1'b1, 16'hCCCC, 16, 1'b0);
        chk("t5_mid_valid_cnt", vcnt1 - v0, 32'd1);
        frame(16'h4444, 16'h5A5A, 16, 1'b0);
        slot(1'b0, 16'h0000, 16, 1'b0);
        chk("t5_valid_cnt", vcnt1 - v0, 32'd2);
        chk("t5_locked", {31'b0, locked1}, 32'd1);

        // T6: left-justified instance, ws and MSB change together
        sel = 1'b0;
        v0 = vcnt0;
        slot(1'b1, 16'h0000, 16, 1'b0);
        frame(16'hC0DE, 16'hC0DE, 16, 1'b0);
        slot(1'b0, 16'h0000, 16, 1'b0);
        chk("t6_valid_cnt", vcnt0 - v0, 32'd1);
        chk("t6_l",      {16'b0, audio_l0}, 32'hC0DE);
        chk("t6_r",      {16'b0, audio_r0}, 32'hC0DE);
        chk("t6_locked", {31'b0, locked0},  32'd1);
        chk("t6_err",    ecnt0,             32'd0);

        idle(10);
        chk("q1_drained", q1.size(), 32'd0);
        chk("q0_drained", q0.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
